cpu_spm_portb_arbiter: RTL and testbench
========================================

// Module: cpu_spm_portb_arbiter
// PURPOSE
//  Shares SPM port B (MEM side) between the CPU MEM stage and a DMA/debug requester.
//  Sits between the MEM stage, the DMA engine and the SPM port B inputs/outputs.
//  MEM normally has priority. A starvation counter forces periodic DMA slots.
//  Tracks read ownership so the 1-cycle synchronous SPM read data goes to the correct requester.
// PARAMETERS
//  SPM_ADDR_W   12  SPM word-address width (equals SPM_ADDR_BUS width)
//  DATA_W       32  word width (equals WORD_DATA_BUS width)
//  STARVE_MAX    4  consecutive cycles DMA may be denied before it gets a forced slot (>=1)
// PORTS
//  clk          in   1           system clock; all state on rising edge
//  reset        in   1           asynchronous, active-high reset
//  mem_as_n     in   1           MEM stage access strobe, active-low
//  mem_rw       in   1           1 = read, 0 = write
//  mem_addr     in   SPM_ADDR_W  MEM word address
//  mem_wr_data  in   DATA_W      MEM write data
//  mem_rd_data  out  DATA_W      read data, 1 cycle after an accepted MEM read
//  mem_stall    out  1           MEM access not accepted this cycle; hold request
//  dma_req      in   1           DMA access request, active-high, held until dma_gnt
//  dma_rw       in   1           1 = read, 0 = write
//  dma_addr     in   SPM_ADDR_W  DMA word address
//  dma_wr_data  in   DATA_W      DMA write data
//  dma_gnt      out  1           DMA access accepted this cycle (combinational)
//  dma_rd_data  out  DATA_W      read data, valid when dma_rd_vld = 1
//  dma_rd_vld   out  1           registered; high 1 cycle after a granted DMA read
//  spm_as_n     out  1           to SPM port B, active-low
//  spm_rw       out  1           to SPM port B (1 = read)
//  spm_addr     out  SPM_ADDR_W  to SPM port B
//  spm_wr_data  out  DATA_W      to SPM port B
//  spm_rd_data  in   DATA_W      from SPM port B; valid 1 cycle after the address
// BEHAVIOUR
//  - Reset values:
//    - starve_cnt = 0, rd_owner = NONE, dma_rd_vld = 0
//    - mem_rd_data and dma_rd_data read as 0
//  - Combinational outputs from current inputs:
//    - spm_as_n = 1, spm_rw = 1, spm_addr = 0 and spm_wr_data = 0 when no grant
//    - mem_stall = 0 and dma_gnt = 0 when no request is present
//  - Grant decision (combinational, every cycle):
//    - MEM request only (mem_as_n = 0) -> MEM granted.
//    - DMA request only -> DMA granted.
//    - Both requesting and starve_cnt < STARVE_MAX -> MEM granted, DMA waits.
//    - Both requesting and starve_cnt == STARVE_MAX -> DMA granted, mem_stall = 1.
//  - Granted side's rw, addr and wr_data are muxed onto spm_*. spm_as_n = 0 only on a grant.
//  - starve_cnt (sequential, saturates at STARVE_MAX):
//    - +1 when dma_req = 1 and not granted
//    - cleared to 0 on any dma_gnt
//    - cleared to 0 when dma_req = 0
//  - rd_owner register (NONE/MEM/DMA) holds the owner of the read issued in the previous cycle:
//    - mem_rd_data = spm_rd_data when rd_owner = MEM, else 0
//    - dma_rd_data = spm_rd_data when rd_owner = DMA, else 0
//    - dma_rd_vld = (rd_owner == DMA)
//  - Writes commit in the grant cycle and produce no read-data response.
//  - Back-to-back grants are allowed every cycle. Throughput is 1 access/cycle. Read latency is 1 cycle.
//  - Reset asserted mid-read: the pending response is dropped (no dma_rd_vld) and the counter clears.
//  - A DMA request removed before grant is a protocol violation. The arbiter simply clears starve_cnt.
//  - A MEM access and a DMA write to the same address in the same cycle cannot occur: only one side is granted.
// CONFIGURATION
//  - Macro SPM_ARB_STARVE_EN:
//    - Defined: starvation counter and forced DMA slot exactly as above.
//    - Undefined: strict MEM priority. DMA is granted only when mem_as_n = 1. mem_stall is constant 0.
//      No starve_cnt register is built.
// TESTING
//  1. Reset: reset = 1 during a DMA read -> dma_rd_vld = 0, spm_as_n = 1, starve_cnt = 0 after release.
//  2. Lone DMA write: 0xDEADBEEF to 0x010, then DMA read of 0x010 ->
//     dma_gnt in both issue cycles; next cycle dma_rd_vld = 1, dma_rd_data = 0xDEADBEEF.
//  3. MEM read: MEM read 0x020 preloaded with 0x12345678 ->
//     mem_stall = 0; mem_rd_data = 0x12345678 one cycle later; dma_rd_vld stays 0.
//  4. Starvation (EN defined, STARVE_MAX = 4): MEM and DMA both requesting continuously ->
//     MEM granted 4 cycles; DMA granted in cycle 5 with mem_stall = 1; pattern repeats every 5 cycles.
//  5. Same stimulus as 4 with EN undefined -> DMA never granted while MEM requests; mem_stall always 0.
//  6. Interleaved reads: MEM read 0x001 in cycle N, forced DMA read 0x002 in cycle N+1 ->
//     cycle N+1: mem_rd_data = [0x001]; cycle N+2: dma_rd_data = [0x002] with dma_rd_vld = 1.

Source files
------------

// File: rtl/cpu_spm_portb_arbiter_if.sv
// Signal bundle between the MEM stage, the DMA requester and SPM port B.
// slave = arbiter side, master = environment (MEM stage, DMA engine, SPM macro).
interface cpu_spm_portb_arbiter_if #(
    parameter int unsigned SPM_ADDR_W = 12,
    parameter int unsigned DATA_W     = 32
);
    logic                  mem_as_n;
    logic                  mem_rw;
    logic [SPM_ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0]     mem_wr_data;
    logic [DATA_W-1:0]     mem_rd_data;
    logic                  mem_stall;

    logic                  dma_req;
    logic                  dma_rw;
    logic [SPM_ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0]     dma_wr_data;
    logic                  dma_gnt;
    logic [DATA_W-1:0]     dma_rd_data;
    logic                  dma_rd_vld;

    logic                  spm_as_n;
    logic                  spm_rw;
    logic [SPM_ADDR_W-1:0] spm_addr;
    logic [DATA_W-1:0]     spm_wr_data;
    logic [DATA_W-1:0]     spm_rd_data;

    modport slave (
        input  mem_as_n, mem_rw, mem_addr, mem_wr_data,
        input  dma_req, dma_rw, dma_addr, dma_wr_data,
        input  spm_rd_data,
        output mem_rd_data, mem_stall,
        output dma_gnt, dma_rd_data, dma_rd_vld,
        output spm_as_n, spm_rw, spm_addr, spm_wr_data
    );

    modport master (
        output mem_as_n, mem_rw, mem_addr, mem_wr_data,
        output dma_req, dma_rw, dma_addr, dma_wr_data,
        output spm_rd_data,
        input  mem_rd_data, mem_stall,
        input  dma_gnt, dma_rd_data, dma_rd_vld,
        input  spm_as_n, spm_rw, spm_addr, spm_wr_data
    );
endinterface

// File: rtl/cpu_spm_portb_arbiter.sv
// SPM port B arbiter: MEM stage has priority over DMA, 1-cycle read data steered to its owner.
// Define SPM_ARB_STARVE_EN to build the starvation counter that forces periodic DMA slots.
module cpu_spm_portb_arbiter #(
    parameter int unsigned SPM_ADDR_W = 12,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input logic                    clk,
    input logic                    reset,
    cpu_spm_portb_arbiter_if.slave bus
);

    if (STARVE_MAX < 1) begin : g_param_check
        $error("STARVE_MAX must be at least 1");
    end

    typedef enum logic [1:0] {
        OwnNone,
        OwnMem,
        OwnDma
    } owner_e;

    owner_e rd_owner_q, rd_owner_d;
    logic   mem_req;
    logic   mem_gnt;
    logic   dma_gnt;

    assign mem_req = ~bus.mem_as_n;

`ifdef SPM_ARB_STARVE_EN
    localparam int unsigned CntW = $clog2(STARVE_MAX + 1);

    logic [CntW-1:0] starve_cnt_q, starve_cnt_d;
    logic            dma_force;

    assign dma_force = (starve_cnt_q == CntW'(STARVE_MAX));

    always_comb begin
        dma_gnt       = bus.dma_req & (~mem_req | dma_force);
        mem_gnt       = mem_req & ~dma_gnt;
        bus.mem_stall = mem_req & dma_gnt;
    end

    // Any cycle without a pending DMA request, or with a grant, restarts the count.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!bus.dma_req || dma_gnt) begin
            starve_cnt_d = '0;
        end else if (!dma_force) begin
            starve_cnt_d = starve_cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`else
    always_comb begin
        dma_gnt       = bus.dma_req & ~mem_req;
        mem_gnt       = mem_req;
        bus.mem_stall = 1'b0;
    end
`endif

    assign bus.dma_gnt = dma_gnt;

    always_comb begin
        bus.spm_as_n    = 1'b1;
        bus.spm_rw      = 1'b1;
        bus.spm_addr    = {SPM_ADDR_W{1'b0}};
        bus.spm_wr_data = {DATA_W{1'b0}};
        if (mem_gnt) begin
            bus.spm_as_n    = 1'b0;
            bus.spm_rw      = bus.mem_rw;
            bus.spm_addr    = bus.mem_addr;
            bus.spm_wr_data = bus.mem_wr_data;
        end else if (dma_gnt) begin
            bus.spm_as_n    = 1'b0;
            bus.spm_rw      = bus.dma_rw;
            bus.spm_addr    = bus.dma_addr;
            bus.spm_wr_data = bus.dma_wr_data;
        end
    end

    // Remember who issued this cycle's read so next cycle's SPM data goes back to them.
    always_comb begin
        rd_owner_d = OwnNone;
        if (mem_gnt && bus.mem_rw) begin
            rd_owner_d = OwnMem;
        end else if (dma_gnt && bus.dma_rw) begin
            rd_owner_d = OwnDma;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_owner_q <= OwnNone;
        end else begin
            rd_owner_q <= rd_owner_d;
        end
    end

    always_comb begin
        bus.mem_rd_data = (rd_owner_q == OwnMem) ? bus.spm_rd_data : {DATA_W{1'b0}};
        bus.dma_rd_data = (rd_owner_q == OwnDma) ? bus.spm_rd_data : {DATA_W{1'b0}};
        bus.dma_rd_vld  = (rd_owner_q == OwnDma);
    end

endmodule

// File: tb/tb_cpu_spm_portb_arbiter.sv
// Self-checking bench for cpu_spm_portb_arbiter: vector table, directed corner sequences
// and randomized traffic against a behavioural arbiter/memory model.
module tb_cpu_spm_portb_arbiter;
    localparam int AW   = 12;
    localparam int DW   = 32;
    localparam int SMAX = 4;
`ifdef SPM_ARB_STARVE_EN
    localparam bit StarveEn = 1'b1;
`else
    localparam bit StarveEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cpu_spm_portb_arbiter_if #(.SPM_ADDR_W(AW), .DATA_W(DW)) bus ();

    cpu_spm_portb_arbiter #(
        .SPM_ADDR_W(AW),
        .DATA_W    (DW),
        .STARVE_MAX(SMAX)
    ) u_dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // Synchronous single-port SPM macro model
    logic [DW-1:0] spm_mem [0:(1<<AW)-1] = '{default: '0};
    logic [DW-1:0] spm_q = '0;
    always @(posedge clk) begin
        if (!bus.spm_as_n) begin
            if (bus.spm_rw) spm_q <= spm_mem[bus.spm_addr];
            else            spm_mem[bus.spm_addr] <= bus.spm_wr_data;
        end
    end
    assign bus.spm_rd_data = spm_q;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Behavioural model: denied-streak length, previous read owner and a shadow memory
    logic [DW-1:0] shadow [0:(1<<AW)-1] = '{default: '0};
    int            m_streak;
    int            m_prev;       // 0 none, 1 MEM, 2 DMA
    logic [DW-1:0] m_prev_data;
    logic          e_mem_gnt, e_dma_gnt, e_stall, e_as_n, e_rw;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd, e_mrd, e_drd;
    logic          e_vld;

    task automatic model_reset();
        m_streak    = 0;
        m_prev      = 0;
        m_prev_data = '0;
        e_dma_gnt   = 1'b0;
    endtask

    task automatic model_eval();
        logic mreq, dreq, dwin;
        mreq = !bus.mem_as_n;
        dreq = bus.dma_req;
        if (StarveEn) dwin = dreq && (!mreq || m_streak >= SMAX);
        else          dwin = dreq && !mreq;
        e_dma_gnt = dwin;
        e_mem_gnt = mreq && !dwin;
        e_stall   = mreq && dwin;
        e_as_n    = !(e_mem_gnt || e_dma_gnt);
        e_rw      = e_mem_gnt ? bus.mem_rw : (e_dma_gnt ? bus.dma_rw : 1'b1);
        e_addr    = e_mem_gnt ? bus.mem_addr : (e_dma_gnt ? bus.dma_addr : '0);
        e_wd      = e_mem_gnt ? bus.mem_wr_data : (e_dma_gnt ? bus.dma_wr_data : '0);
        e_mrd     = (m_prev == 1) ? m_prev_data : '0;
        e_drd     = (m_prev == 2) ? m_prev_data : '0;
        e_vld     = (m_prev == 2);
    endtask

    task automatic model_step();
        if (bus.dma_req && !e_dma_gnt) m_streak = (m_streak < SMAX) ? m_streak + 1 : m_streak;
        else                           m_streak = 0;
        m_prev = 0;
        if (e_mem_gnt) begin
            if (bus.mem_rw) begin
                m_prev      = 1;
                m_prev_data = shadow[bus.mem_addr];
            end else begin
                shadow[bus.mem_addr] = bus.mem_wr_data;
            end
        end else if (e_dma_gnt) begin
            if (bus.dma_rw) begin
                m_prev      = 2;
                m_prev_data = shadow[bus.dma_addr];
            end else begin
                shadow[bus.dma_addr] = bus.dma_wr_data;
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_stall"}, bus.mem_stall, e_stall);
        chk({tag, "_gnt"}, bus.dma_gnt, e_dma_gnt);
        chk({tag, "_as_n"}, bus.spm_as_n, e_as_n);
        chk({tag, "_rw"}, bus.spm_rw, e_rw);
        chk({tag, "_addr"}, bus.spm_addr, e_addr);
        chk({tag, "_wd"}, bus.spm_wr_data, e_wd);
        chk({tag, "_mrd"}, bus.mem_rd_data, e_mrd);
        chk({tag, "_drd"}, bus.dma_rd_data, e_drd);
        chk({tag, "_vld"}, bus.dma_rd_vld, e_vld);
    endtask

    task automatic drive(input logic mas_n, input logic mrw, input logic [AW-1:0] maddr,
                         input logic [DW-1:0] mwd, input logic dreq, input logic drw,
                         input logic [AW-1:0] daddr, input logic [DW-1:0] dwd);
        bus.mem_as_n    = mas_n;
        bus.mem_rw      = mrw;
        bus.mem_addr    = maddr;
        bus.mem_wr_data = mwd;
        bus.dma_req     = dreq;
        bus.dma_rw      = drw;
        bus.dma_addr    = daddr;
        bus.dma_wr_data = dwd;
    endtask

    task automatic set_idle();
        drive(1'b1, 1'b1, '0, '0, 1'b0, 1'b1, '0, '0);
    endtask

    task automatic settle();
        @(negedge clk);
        model_eval();
    endtask

    task automatic advance();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_idle();
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    typedef struct {
        logic          mas_n;
        logic          mrw;
        logic [AW-1:0] maddr;
        logic [DW-1:0] mwd;
        logic          dreq;
        logic          drw;
        logic [AW-1:0] daddr;
        logic [DW-1:0] dwd;
        logic          e_stall;
        logic          e_gnt;
        logic          e_as_n;
        logic [AW-1:0] e_addr;
        logic          e_vld;
        logic [DW-1:0] e_mrd;
        logic [DW-1:0] e_drd;
    } vec_t;

    vec_t tbl [9];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{1'b1, 1'b1, 12'h000, 32'h0, 1'b1, 1'b0, 12'h010, 32'hDEADBEEF,
                   1'b0, 1'b1, 1'b0, 12'h010, 1'b0, 32'h0, 32'h0};
        tbl[1] = '{1'b1, 1'b1, 12'h000, 32'h0, 1'b1, 1'b1, 12'h010, 32'h0,
                   1'b0, 1'b1, 1'b0, 12'h010, 1'b0, 32'h0, 32'h0};
        tbl[2] = '{1'b1, 1'b1, 12'h000, 32'h0, 1'b0, 1'b1, 12'h000, 32'h0,
                   1'b0, 1'b0, 1'b1, 12'h000, 1'b1, 32'h0, 32'hDEADBEEF};
        tbl[3] = '{1'b0, 1'b0, 12'h020, 32'h12345678, 1'b0, 1'b1, 12'h000, 32'h0,
                   1'b0, 1'b0, 1'b0, 12'h020, 1'b0, 32'h0, 32'h0};
        tbl[4] = '{1'b0, 1'b1, 12'h020, 32'h0, 1'b0, 1'b1, 12'h000, 32'h0,
                   1'b0, 1'b0, 1'b0, 12'h020, 1'b0, 32'h0, 32'h0};
        tbl[5] = '{1'b1, 1'b1, 12'h000, 32'h0, 1'b0, 1'b1, 12'h000, 32'h0,
                   1'b0, 1'b0, 1'b1, 12'h000, 1'b0, 32'h12345678, 32'h0};
        tbl[6] = '{1'b0, 1'b0, 12'h030, 32'hCAFEF00D, 1'b1, 1'b1, 12'h010, 32'h0,
                   1'b0, 1'b0, 1'b0, 12'h030, 1'b0, 32'h0, 32'h0};
        tbl[7] = '{1'b1, 1'b1, 12'h000, 32'h0, 1'b1, 1'b1, 12'h010, 32'h0,
                   1'b0, 1'b1, 1'b0, 12'h010, 1'b0, 32'h0, 32'h0};
        tbl[8] = '{1'b1, 1'b1, 12'h000, 32'h0, 1'b0, 1'b1, 12'h000, 32'h0,
                   1'b0, 1'b0, 1'b1, 12'h000, 1'b1, 32'h0, 32'hDEADBEEF};

        // Reset state
        reset = 1'b1;
        set_idle();
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_vld", bus.dma_rd_vld, 1'b0);
        chk("rst_mrd", bus.mem_rd_data, 32'h0);
        chk("rst_drd", bus.dma_rd_data, 32'h0);
        chk("rst_as_n", bus.spm_as_n, 1'b1);
        chk("rst_stall", bus.mem_stall, 1'b0);
        chk("rst_gnt", bus.dma_gnt, 1'b0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Vector table
        for (int i = 0; i < 9; i++) begin
            drive(tbl[i].mas_n, tbl[i].mrw, tbl[i].maddr, tbl[i].mwd,
                  tbl[i].dreq, tbl[i].drw, tbl[i].daddr, tbl[i].dwd);
            settle();
            chk($sformatf("tbl%0d_stall", i), bus.mem_stall, tbl[i].e_stall);
            chk($sformatf("tbl%0d_gnt", i), bus.dma_gnt, tbl[i].e_gnt);
            chk($sformatf("tbl%0d_as_n", i), bus.spm_as_n, tbl[i].e_as_n);
            chk($sformatf("tbl%0d_addr", i), bus.spm_addr, tbl[i].e_addr);
            chk($sformatf("tbl%0d_vld", i), bus.dma_rd_vld, tbl[i].e_vld);
            chk($sformatf("tbl%0d_mrd", i), bus.mem_rd_data, tbl[i].e_mrd);
            chk($sformatf("tbl%0d_drd", i), bus.dma_rd_data, tbl[i].e_drd);
            advance();
        end

        // Reset asserted while a DMA read response is pending
        drive(1'b1, 1'b1, '0, '0, 1'b1, 1'b1, 12'h010, '0);
        settle();
        chk("midrd_gnt", bus.dma_gnt, 1'b1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        set_idle();
        model_reset();
        #1;
        chk("midrd_vld", bus.dma_rd_vld, 1'b0);
        chk("midrd_drd", bus.dma_rd_data, 32'h0);
        chk("midrd_as_n", bus.spm_as_n, 1'b1);
        @(posedge clk);
        #1 reset = 1'b0;
        settle();
        check_all("post_rst");
        advance();

        // Build a partial starvation streak, then reset; the forced slot must restart from zero
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 12'h200, 32'h0, 1'b1, 1'b1, 12'h010, '0);
            settle();
            chk("pre_gnt", bus.dma_gnt, 1'b0);
            advance();
        end
        do_reset();

        // Continuous contention
        for (int i = 0; i < 15; i++) begin
            drive(1'b0, 1'b0, 12'h200 + 12'(i), 32'(i), 1'b1, 1'b1, 12'h010, '0);
            settle();
            chk($sformatf("starve%0d_gnt", i), bus.dma_gnt, StarveEn && (i % 5 == 4));
            chk($sformatf("starve%0d_stall", i), bus.mem_stall, StarveEn && (i % 5 == 4));
            check_all("starve");
            advance();
        end
        do_reset();

        // Interleaved MEM read then DMA read
        drive(1'b1, 1'b1, '0, '0, 1'b1, 1'b0, 12'h001, 32'h11111111);
        settle();
        check_all("pre1");
        advance();
        drive(1'b1, 1'b1, '0, '0, 1'b1, 1'b0, 12'h002, 32'h22222222);
        settle();
        check_all("pre2");
        advance();
`ifdef SPM_ARB_STARVE_EN
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 12'h100, 32'h0, 1'b1, 1'b1, 12'h002, '0);
            settle();
            chk("il_wait_gnt", bus.dma_gnt, 1'b0);
            advance();
        end
`endif
        drive(1'b0, 1'b1, 12'h001, '0, 1'b1, 1'b1, 12'h002, '0);
        settle();
        chk("il_n_stall", bus.mem_stall, 1'b0);
        chk("il_n_gnt", bus.dma_gnt, 1'b0);
        advance();
        drive(StarveEn ? 1'b0 : 1'b1, 1'b0, 12'h101, 32'h5, 1'b1, 1'b1, 12'h002, '0);
        settle();
        chk("il_n1_gnt", bus.dma_gnt, 1'b1);
        chk("il_n1_stall", bus.mem_stall, StarveEn);
        chk("il_n1_mrd", bus.mem_rd_data, 32'h11111111);
        chk("il_n1_vld", bus.dma_rd_vld, 1'b0);
        advance();
        drive(1'b0, 1'b0, 12'h101, 32'h5, 1'b0, 1'b1, '0, '0);
        settle();
        chk("il_n2_vld", bus.dma_rd_vld, 1'b1);
        chk("il_n2_drd", bus.dma_rd_data, 32'h22222222);
        chk("il_n2_mrd", bus.mem_rd_data, 32'h0);
        advance();

        // Randomized traffic; DMA holds its request until granted
        set_idle();
        e_dma_gnt = 1'b0;
        for (int c = 0; c < 400; c++) begin
            logic hold;
            hold = bus.dma_req && !e_dma_gnt;
            bus.mem_as_n    = ($urandom_range(0, 9) < 4);
            bus.mem_rw      = 1'($urandom_range(0, 1));
            bus.mem_addr    = AW'($urandom_range(0, 7));
            bus.mem_wr_data = $urandom;
            if (!hold) begin
                bus.dma_req     = 1'($urandom_range(0, 1));
                bus.dma_rw      = 1'($urandom_range(0, 1));
                bus.dma_addr    = AW'($urandom_range(0, 7));
                bus.dma_wr_data = $urandom;
            end
            settle();
            check_all("rnd");
            advance();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
